// File: rtl/keypad_scanner_if.sv
// Keypad scanner bundle: matrix drive/sense plus the debounced key outputs.
//   row_n      keypad rows, active low (driven by the keypad)
//   col_n      column drive, one-hot low
//   button     code of the last accepted key
//   bstate     high while a debounced key is held
//   key_strobe one-cycle pulse in the cycle bstate falls
//   multi_key  high for the scan period after a scan that saw more than one key
// master = scanner side, slave = keypad/consumer side.
interface keypad_scanner_if;
   logic [3:0] row_n;
   logic [3:0] col_n;
   logic [3:0] button;
   logic       bstate;
   logic       key_strobe;
   logic       multi_key;

   modport master (
      input  row_n,
      output col_n, button, bstate, key_strobe, multi_key
   );

   modport slave (
      output row_n,
      input  col_n, button, bstate, key_strobe, multi_key
   );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 active-low matrix keypad scanner with scan-level debounce.
// Walks one low column per SCAN_DIV-cycle slot, collects the row hits of a
// full four-column scan, and runs a debounce FSM once per completed scan.
//   i_hwclk  system clock
//   i_rst_n  asynchronous reset, active low
//   io_kp    keypad_scanner_if.master (row_n in; col_n, button, bstate,
//            key_strobe, multi_key out, all registered)
//
// state   | meaning
// IDLE    | no key accepted, waiting for a single-key scan
// PRESS   | same single key seen on r_cnt consecutive scans
// HELD    | key accepted, bstate high
// RELEASE | key accepted, r_cnt consecutive empty scans seen
module keypad_scanner #(
   parameter int SCAN_DIV       = 12000,
   parameter int DEBOUNCE_SCANS = 4
) (
   input  logic            i_hwclk,
   input  logic            i_rst_n,
   keypad_scanner_if.master io_kp
);

   localparam int DW = $clog2(SCAN_DIV);
   localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
   localparam logic [DW-1:0] LP_DIV_LAST = DW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] LP_DB       = CW'(DEBOUNCE_SCANS);
   localparam logic [CW-1:0] LP_ONE      = CW'(1);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PRESS   = 2'd1,
      ST_HELD    = 2'd2,
      ST_RELEASE = 2'd3
   } state_t;

   function automatic logic [3:0] f_key_code(input logic [1:0] row, input logic [1:0] col);
      logic [3:0] code;
      case ({row, col})
         4'd0:    code = 4'd1;
         4'd1:    code = 4'd2;
         4'd2:    code = 4'd3;
         4'd3:    code = 4'd10;
         4'd4:    code = 4'd4;
         4'd5:    code = 4'd5;
         4'd6:    code = 4'd6;
         4'd7:    code = 4'd11;
         4'd8:    code = 4'd7;
         4'd9:    code = 4'd8;
         4'd10:   code = 4'd9;
         4'd11:   code = 4'd12;
         4'd12:   code = 4'd14;
         4'd13:   code = 4'd0;
         4'd14:   code = 4'd15;
         default: code = 4'd13;
      endcase
      return code;
   endfunction

   logic [3:0]    r_row_meta;
   logic [3:0]    r_row_sync;
   logic [DW-1:0] r_div;
   logic [1:0]    r_col;
   logic [3:0]    r_col_n;
   logic [1:0]    r_acc_cnt;
   logic [3:0]    r_acc_code;
   state_t        r_state;
   logic [CW-1:0] r_cnt;
   logic [3:0]    r_cand;
   logic [3:0]    r_button;
   logic          r_bstate;
   logic          r_strobe;
   logic          r_multi;

   logic          w_slot_end;
   logic          w_scan_end;
   logic [3:0]    w_hits;
   logic [2:0]    w_col_cnt;
   logic [3:0]    w_col_code;
   logic [2:0]    w_sum;
   logic [3:0]    w_scan_code;
   logic          w_none;
   logic          w_single;
   state_t        w_state_nxt;
   logic [CW-1:0] w_cnt_nxt;
   logic [CW-1:0] w_cnt_inc;
   logic [3:0]    w_cand_nxt;
   logic [3:0]    w_button_nxt;
   logic          w_bstate_nxt;
   logic          w_strobe_nxt;

   always_ff @(posedge i_hwclk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_row_meta <= 4'hF;
         r_row_sync <= 4'hF;
      end else begin
         r_row_meta <= io_kp.row_n;
         r_row_sync <= r_row_meta;
      end
   end

   assign w_slot_end = (r_div == LP_DIV_LAST);
   assign w_scan_end = w_slot_end && (r_col == 2'd3);
   assign w_hits     = ~r_row_sync;
   assign w_col_cnt  = {2'b00, w_hits[0]} + {2'b00, w_hits[1]} +
                       {2'b00, w_hits[2]} + {2'b00, w_hits[3]};

   // Code of the lowest hit row; only meaningful when exactly one hit exists.
   always_comb begin
      w_col_code = 4'd0;
      for (int r = 3; r >= 0; r--) begin
         if (w_hits[r]) w_col_code = f_key_code(2'(r), r_col);
      end
   end

   // Running scan total including the slot being sampled right now.
   assign w_sum       = {1'b0, r_acc_cnt} + w_col_cnt;
   assign w_scan_code = (r_acc_cnt == 2'd0) ? w_col_code : r_acc_code;
   assign w_none      = (w_sum == 3'd0);
   assign w_single    = (w_sum == 3'd1);

   always_ff @(posedge i_hwclk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_div      <= '0;
         r_col      <= 2'd0;
         r_col_n    <= 4'b1110;
         r_acc_cnt  <= 2'd0;
         r_acc_code <= 4'd0;
      end else if (w_slot_end) begin
         r_div   <= '0;
         r_col   <= r_col + 2'd1;
         r_col_n <= {r_col_n[2:0], r_col_n[3]};
         if (r_col == 2'd3) begin
            r_acc_cnt  <= 2'd0;
            r_acc_code <= 4'd0;
         end else begin
            // Saturate at 2: anything beyond one hit is already MULTI.
            r_acc_cnt  <= (w_sum >= 3'd2) ? 2'd2 : w_sum[1:0];
            r_acc_code <= w_scan_code;
         end
      end else begin
         r_div <= r_div + DW'(1);
      end
   end

   // State register
   always_ff @(posedge i_hwclk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state  <= ST_IDLE;
         r_cnt    <= '0;
         r_cand   <= 4'd0;
         r_button <= 4'd0;
         r_bstate <= 1'b0;
         r_strobe <= 1'b0;
         r_multi  <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_cnt    <= w_cnt_nxt;
         r_cand   <= w_cand_nxt;
         r_button <= w_button_nxt;
         r_bstate <= w_bstate_nxt;
         r_strobe <= w_strobe_nxt;
         if (w_scan_end) r_multi <= (w_sum >= 3'd2);
      end
   end

   // Next-state logic, stepped once per completed scan
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_cand_nxt  = r_cand;
      w_cnt_inc   = r_cnt + LP_ONE;
      if (w_scan_end) begin
         case (r_state)
            ST_IDLE: begin
               if (w_single) begin
                  w_cand_nxt  = w_scan_code;
                  w_cnt_nxt   = LP_ONE;
                  w_state_nxt = (LP_ONE == LP_DB) ? ST_HELD : ST_PRESS;
               end
            end
            ST_PRESS: begin
               if (w_single && (w_scan_code == r_cand)) begin
                  w_cnt_nxt = w_cnt_inc;
                  if (w_cnt_inc == LP_DB) w_state_nxt = ST_HELD;
               end else if (w_single) begin
                  w_cand_nxt = w_scan_code;
                  w_cnt_nxt  = LP_ONE;
               end else begin
                  w_state_nxt = ST_IDLE;
               end
            end
            ST_HELD: begin
               if (w_none) begin
                  w_cnt_nxt   = LP_ONE;
                  w_state_nxt = (LP_ONE == LP_DB) ? ST_IDLE : ST_RELEASE;
               end
            end
            default: begin
               if (w_none) begin
                  w_cnt_nxt = w_cnt_inc;
                  if (w_cnt_inc == LP_DB) w_state_nxt = ST_IDLE;
               end else begin
                  w_state_nxt = ST_HELD;
               end
            end
         endcase
      end
   end

   // Output logic: bstate tracks HELD/RELEASE; button loads only on the rising edge of bstate
   always_comb begin
      w_bstate_nxt = (w_state_nxt == ST_HELD) || (w_state_nxt == ST_RELEASE);
      w_strobe_nxt = r_bstate && !w_bstate_nxt;
      w_button_nxt = (w_bstate_nxt && !r_bstate) ? w_cand_nxt : r_button;
   end

   assign io_kp.col_n      = r_col_n;
   assign io_kp.button     = r_button;
   assign io_kp.bstate     = r_bstate;
   assign io_kp.key_strobe = r_strobe;
   assign io_kp.multi_key  = r_multi;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a keypad matrix model, a scan-level reference
// model (run lengths of identical scan results), a per-cycle compare process,
// directed scenarios with literal expectations, then random key patterns.
module tb_keypad_scanner;
   localparam int SD   = 4;
   localparam int DB   = 3;
   localparam int SCAN = 4 * SD;
   localparam logic [15:0] K1 = 16'h0001;
   localparam logic [15:0] K2 = 16'h0002;
   localparam logic [15:0] K5 = 16'h0020;
   localparam logic [15:0] K9 = 16'h0400;
   localparam logic [15:0] KH = 16'h4000;

   logic hwclk = 1'b0;
   logic rst_n = 1'b0;
   always #5 hwclk = ~hwclk;

   keypad_scanner_if kp();

   keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DB)) dut (
      .i_hwclk (hwclk),
      .i_rst_n (rst_n),
      .io_kp   (kp)
   );

   logic [15:0] keys = '0;
   int keymap [16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};

   // Pressed key at row r / col c shorts row r low while column c is driven low.
   always_comb begin
      kp.row_n = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (keys[r*4+c] && !kp.col_n[c]) kp.row_n[r] = 1'b0;
   end

   int n_tests = 0;
   int n_fail  = 0;
   int n_strobes = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: e counts clock edges since reset; a scan ends every SCAN edges.
   int          e = 0;
   logic [3:0]  exp_button = 4'd0;
   logic        exp_bstate = 1'b0;
   logic        exp_strobe = 1'b0;
   logic        exp_multi  = 1'b0;

   initial begin
      int run_key, run_len, rel_len, nk, k;
      run_key = -1; run_len = 0; rel_len = 0;
      forever begin
         @(posedge hwclk or negedge rst_n);
         if (!rst_n) begin
            e = 0; run_key = -1; run_len = 0; rel_len = 0;
            exp_button = 4'd0; exp_bstate = 1'b0; exp_strobe = 1'b0; exp_multi = 1'b0;
         end else begin
            e++;
            exp_strobe = 1'b0;
            if (e % SCAN == 0) begin
               nk = $countones(keys);
               exp_multi = (nk > 1);
               k = -1;
               for (int i = 0; i < 16; i++) if (keys[i]) k = keymap[i];
               if (!exp_bstate) begin
                  if (nk == 1) begin
                     if (run_len > 0 && k == run_key) run_len++;
                     else begin run_key = k; run_len = 1; end
                     if (run_len == DB) begin
                        exp_bstate = 1'b1;
                        exp_button = 4'(k);
                        run_len = 0;
                     end
                  end else begin
                     run_len = 0;
                  end
               end else begin
                  if (nk == 0) begin
                     rel_len++;
                     if (rel_len == DB) begin
                        exp_bstate = 1'b0;
                        exp_strobe = 1'b1;
                        rel_len = 0;
                     end
                  end else begin
                     rel_len = 0;
                  end
               end
            end
         end
      end
   end

   // Per-cycle compare, away from the active edge
   initial begin
      logic [3:0] ec;
      forever begin
         @(negedge hwclk);
         ec = ~(4'b0001 << ((e / SD) % 4));
         check("col_n", 32'(kp.col_n), 32'(ec));
         check("button", 32'(kp.button), 32'(exp_button));
         check("bstate", 32'(kp.bstate), 32'(exp_bstate));
         check("key_strobe", 32'(kp.key_strobe), 32'(exp_strobe));
         check("multi_key", 32'(kp.multi_key), 32'(exp_multi));
         if (kp.key_strobe === 1'b1) n_strobes++;
      end
   end

   task automatic scan(input logic [15:0] m, input int n);
      keys = m;
      repeat (n * SCAN) @(negedge hwclk);
   endtask

   initial begin
      int s0;
      logic [15:0] m;
      int sel;
      rst_n = 1'b0;
      keys  = '0;
      repeat (3) @(negedge hwclk);
      check("rst_col_n", 32'(kp.col_n), 32'd14);
      check("rst_button", 32'(kp.button), 32'd0);
      check("rst_bstate", 32'(kp.bstate), 32'd0);
      check("rst_strobe", 32'(kp.key_strobe), 32'd0);
      check("rst_multi", 32'(kp.multi_key), 32'd0);
      rst_n = 1'b1;

      // Column walk with no keys
      repeat (5) @(negedge hwclk);
      check("walk_col1", 32'(kp.col_n), 32'd13);
      repeat (SCAN*2 - 5) @(negedge hwclk);

      // Clean press of '5'
      scan(K5, 2);
      check("press5_early", 32'(kp.bstate), 32'd0);
      scan(K5, 1);
      check("press5_bstate", 32'(kp.bstate), 32'd1);
      check("press5_button", 32'(kp.button), 32'd5);
      scan(K5, 7);
      scan('0, 2);
      check("rel5_early", 32'(kp.bstate), 32'd1);
      s0 = n_strobes;
      scan('0, 1);
      check("rel5_bstate", 32'(kp.bstate), 32'd0);
      check("rel5_strobe", 32'(kp.key_strobe), 32'd1);
      check("rel5_button", 32'(kp.button), 32'd5);
      #1;
      check("rel5_strobe_count", 32'(n_strobes - s0), 32'd1);

      // Press bounce then release bounce on '#'
      scan(KH, 2);
      scan('0, 1);
      scan(KH, 2);
      check("bounce_early", 32'(kp.bstate), 32'd0);
      scan(KH, 1);
      check("bounce_bstate", 32'(kp.bstate), 32'd1);
      check("bounce_button", 32'(kp.button), 32'd15);
      scan(KH, 1);
      s0 = n_strobes;
      scan('0, 1);
      scan(KH, 2);
      check("relbounce_bstate", 32'(kp.bstate), 32'd1);
      #1;
      check("relbounce_nostrobe", 32'(n_strobes - s0), 32'd0);
      scan('0, 3);
      check("hash_released", 32'(kp.bstate), 32'd0);

      // Multi-key
      scan(K1 | K2, 3);
      check("multi_bstate", 32'(kp.bstate), 32'd0);
      check("multi_flag", 32'(kp.multi_key), 32'd1);
      scan('0, 1);
      check("multi_clear", 32'(kp.multi_key), 32'd0);
      scan(K1, 3);
      check("hold1_bstate", 32'(kp.bstate), 32'd1);
      scan(K1 | K9, 2);
      check("rollover_button", 32'(kp.button), 32'd1);
      check("rollover_multi", 32'(kp.multi_key), 32'd1);
      check("rollover_bstate", 32'(kp.bstate), 32'd1);

      // Reset while held
      s0 = n_strobes;
      #2 rst_n = 1'b0;
      #1;
      check("midrst_bstate", 32'(kp.bstate), 32'd0);
      check("midrst_strobe", 32'(kp.key_strobe), 32'd0);
      check("midrst_col_n", 32'(kp.col_n), 32'd14);
      keys = '0;
      repeat (2) @(negedge hwclk);
      rst_n = 1'b1;
      scan('0, 2);
      check("midrst_nostrobe", 32'(n_strobes - s0), 32'd0);

      // Random key patterns
      for (int seg = 0; seg < 150; seg++) begin
         sel = int'($urandom_range(0, 9));
         if (sel < 3) m = '0;
         else if (sel < 8) m = 16'h0001 << $urandom_range(0, 15);
         else m = (16'h0001 << $urandom_range(0, 15)) | (16'h0001 << $urandom_range(0, 15));
         scan(m, int'($urandom_range(1, 5)));
      end
      scan('0, 4);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
